// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Imported by uart_rx and uart_tx.
package uart_pkg;

  localparam int SYS_CLK_HZ  = 200_000_000;
  localparam int BAUD        = 9600;
  localparam int CLK_PER_BIT = SYS_CLK_HZ / BAUD;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Byte output bundle of the UART receiver.
// master drives, slave consumes.
interface uart_rx_if;

  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;

  modport master (
    output rx_data,
    output rx_done,
    output frame_err
  );

  modport slave (
    input rx_data,
    input rx_done,
    input frame_err
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs.
// Reset value is a parameter so idle-high lines stay quiet.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling.
// Emits one-cycle rx_done per good byte, frame_err on bad stop.
module uart_rx #(
  parameter int CLK_PER_BIT = uart_pkg::CLK_PER_BIT,
  parameter int CNT_W       = $clog2(CLK_PER_BIT)
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_port,
  uart_rx_if.master  rx_if
);

  import uart_pkg::*;

  localparam int HALF_TC = CLK_PER_BIT / 2 - 1;
  localparam int FULL_TC = CLK_PER_BIT - 1;
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(HALF_TC);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FULL_TC);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic            w_rx_s;
  logic            r_rx_s_d;
  logic            w_fall;

  rx_state_e       r_state;
  rx_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]      r_bit;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic [7:0]      r_data;
  logic [7:0]      w_data_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            r_err;
  logic            w_err_nxt;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (rx_port),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_rx_s_d <= 1'b1;
    else            r_rx_s_d <= w_rx_s;
  end

  // Edge-only start: a held-low line never restarts a frame.
  assign w_fall = r_rx_s_d & ~w_rx_s;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (w_fall) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      DATA: begin
        if (r_cnt == C_FULL) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_nxt   = '0;
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      STOP: begin
        if (r_cnt == C_FULL) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          if (w_rx_s) begin
            w_data_nxt = r_shift;
            w_done_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rx_if.rx_data   = r_data;
  assign rx_if.rx_done   = r_done;
  assign rx_if.frame_err = r_err;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit.
// Driver queues expected bytes; monitor checks on each pulse.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int LAT = 3 + 1 + CPB / 2 + 9 * CPB;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic rx_port   = 1'b1;

  uart_rx_if u_if ();

  uart_rx #(
    .CLK_PER_BIT (CPB)
  ) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_port   (rx_port),
    .rx_if     (u_if)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         n_chk   = 0;
  int         n_pass  = 0;
  int         n_pulse = 0;
  int         n_exp   = 0;
  logic [7:0] last_good = 8'h00;
  bit         prev_pulse = 1'b0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  nm, act, exp_v);
  endtask

  task automatic chk_near(string nm, int act, int exp_v);
    n_chk++;
    if (act >= exp_v - 1 && act <= exp_v + 1) n_pass++;
    else $display("FAIL %s: got %0d want %0d +-1",
                  nm, act, exp_v);
  endtask

  task automatic wait_until(int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic idle(int n);
    wait_until(cyc + n);
  endtask

  // p10: bit period in tenths of a clock; n: frame slots driven
  task automatic send(logic [7:0] d, bit stop, int p10,
                      bit expect_it, int n);
    int         c0;
    logic [9:0] f;
    exp_t       e;
    f  = {stop, d, 1'b0};
    c0 = cyc;
    if (expect_it) begin
      e.err  = !stop;
      e.data = d;
      e.cyc  = c0 + LAT;
      q.push_back(e);
      n_exp++;
    end
    for (int k = 0; k < n; k++) begin
      wait_until(c0 + (k * p10) / 10);
      rx_port = f[k];
    end
    if (n < 10) wait_until(c0 + (n * p10) / 10 - CPB / 2);
    else        wait_until(c0 + p10);
  endtask

  always @(negedge sys_clk) begin
    bit   pulse;
    exp_t e;
    if (!sys_rst_n) begin
      prev_pulse = 1'b0;
    end else begin
      pulse = u_if.rx_done | u_if.frame_err;
      if (pulse) begin
        n_pulse++;
        chk("exclusive", 32'(u_if.rx_done & u_if.frame_err), 0);
        chk("pulse_width", 32'(prev_pulse), 0);
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b cyc=%0d",
                   u_if.rx_done, u_if.frame_err, cyc);
        end else begin
          e = q.pop_front();
          chk("kind_err", 32'(u_if.frame_err), 32'(e.err));
          if (!e.err) last_good = e.data;
          chk("rx_data", 32'(u_if.rx_data), 32'(last_good));
          chk_near("latency", cyc, e.cyc);
        end
      end
      prev_pulse = pulse;
    end
  end

  initial begin
    int wait_n;
    sys_rst_n = 1'b0;
    rx_port   = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_data", 32'(u_if.rx_data), 0);
    chk("rst_done", 32'(u_if.rx_done), 0);
    chk("rst_err", 32'(u_if.frame_err), 0);
    sys_rst_n = 1'b1;
    idle(20);

    send(8'h55, 1'b1, 160, 1'b1, 10);
    idle(30);

    send(8'hA5, 1'b1, 160, 1'b1, 10);
    send(8'h3C, 1'b1, 160, 1'b1, 10);
    idle(30);

    rx_port = 1'b0;
    idle(3);
    rx_port = 1'b1;
    idle(30);
    chk("glitch_no_pulse", 32'(n_pulse), 32'(n_exp));
    send(8'h81, 1'b1, 160, 1'b1, 10);
    idle(30);

    send(8'hFF, 1'b0, 160, 1'b1, 10);
    idle(40);
    rx_port = 1'b1;
    idle(200);
    chk("break_no_restart", 32'(n_pulse), 32'(n_exp));
    send(8'h6E, 1'b1, 160, 1'b1, 10);
    idle(30);

    send(8'h12, 1'b1, 160, 1'b0, 6);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(u_if.rx_data), 0);
    chk("mid_rst_done", 32'(u_if.rx_done), 0);
    chk("mid_rst_err", 32'(u_if.frame_err), 0);
    last_good = 8'h00;
    rx_port   = 1'b1;
    idle(5);
    sys_rst_n = 1'b1;
    idle(20);
    send(8'hC3, 1'b1, 160, 1'b1, 10);
    idle(30);

    send(8'h00, 1'b1, 163, 1'b1, 10);
    send(8'hFF, 1'b1, 163, 1'b1, 10);
    idle(30);

    for (int i = 0; i < 10; i++) begin
      send(8'($urandom), 1'b1, 157 + int'($urandom_range(0, 6)),
           1'b1, 10);
      idle(int'($urandom_range(0, 20)));
    end

    wait_n = 0;
    while (q.size() != 0 && wait_n < 400) begin
      idle(1);
      wait_n++;
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d outputs still pending",
               q.size());
    end
    idle(20);
    chk("pulse_count", 32'(n_pulse), 32'(n_exp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that turns the serial input line into bytes for the loopback path. It samples 8N1 frames LSB first at a fixed baud set by `CLK_PER_BIT`. Each valid byte is presented on `rx_data` with a one-cycle `rx_done` strobe, which is the byte source for `uart_tx`. Frames with a bad stop bit are flagged and dropped.

## Interface
- `CLK_PER_BIT`, default 20833: sys_clk cycles per bit (200 MHz / 9600 baud). Must be ≥ 8.
- `CNT_W`, default `$clog2(CLK_PER_BIT)` (15 for the default): bit-period counter width.
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `rx_port` in 1: serial line. Asynchronous to `sys_clk`; idles high.
- `rx_data` out 8: last valid byte. Holds until the next valid frame completes.
- `rx_done` out 1: one-cycle pulse; `rx_data` is valid in the same cycle and stays valid afterwards.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- Input synchronizer:
  - `rx_port` passes through 2 flops, both reset to 1, giving `rx_s`.
  - A third flop, `rx_s_d` (reset 1), feeds the falling-edge detect: `rx_s_d & ~rx_s`.
- FSM states: IDLE, START, DATA, STOP. Reset state is IDLE.
  - IDLE: counters cleared. On a falling edge, go to START.
  - START: count 0 to `CLK_PER_BIT/2 - 1`, then sample `rx_s` at mid start bit.
    - Sample 0: go to DATA with the counter cleared.
    - Sample 1: false start (glitch). Return to IDLE with no output.
  - DATA: count 0 to `CLK_PER_BIT - 1`; at terminal count, sample `rx_s` (mid-bit).
    - Each sample shifts into `shift_reg[7]`, shifting right (LSB first).
    - `bit_cnt` runs 0 to 7. After sample 7, go to STOP.
  - STOP: count a full bit period, then sample.
    - Sample 1: `rx_data <= shift_reg` and pulse `rx_done`.
    - Sample 0: pulse `frame_err`; `rx_data` is unchanged.
    - Either way, return to IDLE immediately at mid stop bit, so a start bit right after the stop bit is caught.
- After a framing error, or during a break (line held low), IDLE needs a rising then falling edge before it starts a new frame. There is no level-triggered restart.
- Width and arithmetic rules:
  - Bit counter is `CNT_W` bits and compares against `CLK_PER_BIT - 1` (integer constant).
  - Half-period uses integer division; odd `CLK_PER_BIT` truncates.
  - `bit_cnt` is 3 bits and never wraps within a frame.
- `rx_done` and `frame_err` are registered, mutually exclusive, and never asserted for more than 1 cycle.
- Asynchronous reset mid-frame:
  - FSM goes to IDLE; counters and `shift_reg` go to 0.
  - `rx_data` = 0x00, `rx_done` = 0, `frame_err` = 0.
  - A frame already in progress at reset release is not received. If the line is low at release, the synchronizer flops were reset to 1, so this reads as a falling edge and the receiver enters START. The frame is then received only if it happens to pass START/STOP validation; the bench does not rely on this.

## Timing
- Reset values: `rx_data` = 0x00, `rx_done` = 0, `frame_err` = 0.
- Latency: falling edge detected at cycle T; `rx_done` or `frame_err` is high at T + 1 + `CLK_PER_BIT/2` + 9·`CLK_PER_BIT` (±1).
  - Counted from the `rx_port` transition, add 3 cycles for the sync and edge pipeline.
- Sample points sit at `CLK_PER_BIT/2` + k·`CLK_PER_BIT` after start detect, for k = 0 (start), 1–8 (data), 9 (stop).
- Throughput: back-to-back frames with zero idle bits are supported.
- Baud tolerance: ±2% clock mismatch must still decode (mid-bit sampling).
- No handshake and no backpressure. The consumer must take the byte before the next `rx_done`.
  - `rx_data` stays stable for at least 9.5 bit periods after `rx_done`, which covers the downstream transmitter's capture window.

## Structure
- Shared package `uart_pkg`:
  - `SYS_CLK_HZ` (200_000_000), `BAUD` (9600), and `CLK_PER_BIT` derived from them. This is shared with `uart_tx`.
  - FSM state encoding (localparams, 2 bits).
- Sub-module `sync_2ff`: generic 2-flop synchronizer with a reset-value parameter. It is reused for other asynchronous inputs.
- Everything else lives in `uart_rx`: edge detect, FSM, counters, shift register, output registers.

## Test plan
All runs use `CLK_PER_BIT` = 16; `sys_clk` is free-running.
- Single frame 0x55, then idle → `rx_data` = 0x55, exactly one `rx_done` pulse at the latency above (±1), `frame_err` = 0.
- Back-to-back 0xA5 then 0x3C with no idle gap → two `rx_done` pulses 160 cycles apart; `rx_data` reads 0xA5, then 0x3C.
- 3-cycle low glitch on an idle line → no `rx_done`, no `frame_err`; FSM returns to IDLE; a following 0x81 frame is received correctly.
- 0xFF frame with the stop bit driven 0 and the line held low 40 cycles → one `frame_err` pulse, `rx_data` holds its previous value, and no new frame starts until the line rises and falls again.
- `sys_rst_n` asserted during data bit 4 of 0x12 → all outputs reset immediately. After release with the line idle-high, a full 0xC3 frame → `rx_data` = 0xC3.
- 0x00 and 0xFF frames with the bit period stretched to 16.3 cycles (+2%) → both bytes received, no `frame_err`.
